// File: rtl/ft_wishbone_master_if.sv
// Wishbone classic bus between ft_wishbone_master and a single slave.
// The master drives adr/dat/we/stb/cyc/sel; the slave returns dat_i and ack.
interface ft_wishbone_master_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/ft_wishbone_master.sv
// Runs decoded FT245 host requests (ping/write/read) as Wishbone classic single transfers
// and returns response packets. Optional ack timeout: define WB_TIMEOUT_EN.
//
// Handshakes: ih_ready is a one-cycle pulse honoured only while master_ready=1;
// oh_en is a registered one-cycle pulse issued only after oh_ready was sampled high,
// and out_* change only on the edge that raises oh_en.
module ft_wishbone_master #(
   parameter logic [31:0] TIMEOUT = 32'd1000,
   parameter logic [3:0]  SEL_ALL = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        master_ready,
   input  logic        ih_ready,
   input  logic [31:0] in_command,
   input  logic [31:0] in_address,
   input  logic [27:0] in_data_count,
   input  logic [31:0] in_data,
   input  logic        oh_ready,
   output logic        oh_en,
   output logic [31:0] out_status,
   output logic [31:0] out_address,
   output logic [27:0] out_data_count,
   output logic [31:0] out_data,
   output logic [2:0]  state_dbg,
   ft_wishbone_master_if.master wb
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WB_WRITE   = 3'd1,
      WAIT_WDATA = 3'd2,
      WB_READ    = 3'd3,
      WAIT_OH    = 3'd4,
      SEND_DATA  = 3'd5,
      SEND_RESP  = 3'd6
   } state_t;

   state_t      state, state_n;
   logic        mr_n, oh_en_n, first, first_n;
   logic [31:0] cmd, cmd_n, start, start_n, addr, addr_n;
   logic [27:0] count, count_n, remaining, remaining_n;
   logic [31:0] rdata, rdata_n, resp_status, resp_status_n, resp_addr, resp_addr_n;
   logic [31:0] out_status_n, out_address_n, out_data_n;
   logic [27:0] out_count_n;
   logic [31:0] adr, adr_n, dat, dat_n;
   logic        we, we_n, stb, stb_n;
`ifdef WB_TIMEOUT_EN
   logic [31:0] tmo, tmo_n;
`endif

   // cyc and stb come from one register so they always move together.
   assign wb.wb_adr_o = adr;
   assign wb.wb_dat_o = dat;
   assign wb.wb_we_o  = we;
   assign wb.wb_stb_o = stb;
   assign wb.wb_cyc_o = stb;
   assign wb.wb_sel_o = stb ? SEL_ALL : 4'h0;
   assign state_dbg   = state;

   always_comb begin
      state_n       = state;
      mr_n          = master_ready;
      oh_en_n       = 1'b0;
      first_n       = first;
      cmd_n         = cmd;
      start_n       = start;
      addr_n        = addr;
      count_n       = count;
      remaining_n   = remaining;
      rdata_n       = rdata;
      resp_status_n = resp_status;
      resp_addr_n   = resp_addr;
      out_status_n  = out_status;
      out_address_n = out_address;
      out_count_n   = out_data_count;
      out_data_n    = out_data;
      adr_n         = adr;
      dat_n         = dat;
      we_n          = we;
      stb_n         = stb;
      case (state)
         IDLE: begin
            mr_n = 1'b1;
            if (ih_ready && master_ready) begin
               mr_n        = 1'b0;
               cmd_n       = in_command;
               start_n     = in_address;
               addr_n      = in_address;
               count_n     = in_data_count;
               remaining_n = in_data_count;
               first_n     = 1'b1;
               case (in_command[3:0])
                  4'd0: begin
                     resp_status_n = ~in_command;
                     resp_addr_n   = 32'd0;
                     state_n       = SEND_RESP;
                  end
                  4'd1: begin
                     stb_n   = 1'b1;
                     we_n    = 1'b1;
                     adr_n   = in_address;
                     dat_n   = in_data;
                     state_n = WB_WRITE;
                  end
                  4'd2: begin
                     stb_n   = 1'b1;
                     we_n    = 1'b0;
                     adr_n   = in_address;
                     state_n = WB_READ;
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
         WB_WRITE: begin
            if (stb && wb.wb_ack_i) begin
               stb_n  = 1'b0;
               we_n   = 1'b0;
               addr_n = addr + 32'd1;
               if (remaining != 28'd0) begin
                  remaining_n = remaining - 28'd1;
                  mr_n        = 1'b1;
                  state_n     = WAIT_WDATA;
               end else begin
                  resp_status_n = ~cmd;
                  resp_addr_n   = start;
                  state_n       = SEND_RESP;
               end
            end
         end
         WAIT_WDATA: begin
            if (ih_ready && master_ready) begin
               mr_n    = 1'b0;
               stb_n   = 1'b1;
               we_n    = 1'b1;
               adr_n   = addr;
               dat_n   = in_data;
               state_n = WB_WRITE;
            end
         end
         WB_READ: begin
            if (stb && wb.wb_ack_i) begin
               stb_n   = 1'b0;
               rdata_n = wb.wb_dat_i;
               state_n = first ? WAIT_OH : SEND_DATA;
            end
         end
         WAIT_OH, SEND_DATA: begin
            if (oh_ready) begin
               oh_en_n    = 1'b1;
               out_data_n = rdata;
               // Only the first beat carries a fresh header; later beats keep it.
               if (state == WAIT_OH) begin
                  out_status_n  = ~cmd;
                  out_address_n = start;
                  out_count_n   = count;
                  first_n       = 1'b0;
               end
               if (remaining != 28'd0) begin
                  remaining_n = remaining - 28'd1;
                  addr_n      = addr + 32'd1;
                  adr_n       = addr + 32'd1;
                  stb_n       = 1'b1;
                  state_n     = WB_READ;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         SEND_RESP: begin
            if (oh_ready) begin
               oh_en_n       = 1'b1;
               out_status_n  = resp_status;
               out_address_n = resp_addr;
               out_count_n   = 28'd0;
               out_data_n    = 32'd0;
               state_n       = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef WB_TIMEOUT_EN
      tmo_n = tmo;
      if (stb && !wb.wb_ack_i) begin
         // Abort: unsent write words are dropped, so master_ready stays low.
         if (tmo == TIMEOUT - 32'd1) begin
            stb_n         = 1'b0;
            we_n          = 1'b0;
            mr_n          = 1'b0;
            resp_status_n = {1'b0, ~cmd[30:4], 4'hF};
            resp_addr_n   = addr;
            state_n       = SEND_RESP;
         end else begin
            tmo_n = tmo + 32'd1;
         end
      end else if (!stb) begin
         tmo_n = 32'd0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         master_ready   <= 1'b0;
         oh_en          <= 1'b0;
         first          <= 1'b0;
         cmd            <= '0;
         start          <= '0;
         addr           <= '0;
         count          <= '0;
         remaining      <= '0;
         rdata          <= '0;
         resp_status    <= '0;
         resp_addr      <= '0;
         out_status     <= '0;
         out_address    <= '0;
         out_data_count <= '0;
         out_data       <= '0;
         adr            <= '0;
         dat            <= '0;
         we             <= 1'b0;
         stb            <= 1'b0;
      end else begin
         state          <= state_n;
         master_ready   <= mr_n;
         oh_en          <= oh_en_n;
         first          <= first_n;
         cmd            <= cmd_n;
         start          <= start_n;
         addr           <= addr_n;
         count          <= count_n;
         remaining      <= remaining_n;
         rdata          <= rdata_n;
         resp_status    <= resp_status_n;
         resp_addr      <= resp_addr_n;
         out_status     <= out_status_n;
         out_address    <= out_address_n;
         out_data_count <= out_count_n;
         out_data       <= out_data_n;
         adr            <= adr_n;
         dat            <= dat_n;
         we             <= we_n;
         stb            <= stb_n;
      end
   end

`ifdef WB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo <= '0;
      else     tmo <= tmo_n;
   end
`endif

endmodule

// File: tb/tb_ft_wishbone_master.sv
// Directed bench for ft_wishbone_master: ping, write, stalled read, back-pressure,
// ack timeout (when WB_TIMEOUT_EN is defined) and asynchronous reset mid-read.
module tb_ft_wishbone_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        master_ready, ih_ready, oh_ready, oh_en;
   logic [31:0] in_command, in_address, in_data;
   logic [27:0] in_data_count;
   logic [31:0] out_status, out_address, out_data;
   logic [27:0] out_data_count;
   logic [2:0]  state_dbg;

   int errors = 0;
   int checks = 0;

   logic [31:0] oh_st_q[$], oh_ad_q[$], oh_dt_q[$];
   logic [27:0] oh_cn_q[$];
   logic [31:0] wr_adr_q[$], wr_dat_q[$];
   logic [31:0] exp_q[$];
   int          stb_rises = 0, oh_viol = 0, sel_viol = 0;
   logic        stb_prev = 1'b0, oh_prev = 1'b0, slave_en = 1'b1;

`ifdef WB_TIMEOUT_EN
   localparam logic [31:0] TMO = 32'd8;
`else
   localparam logic [31:0] TMO = 32'd1000;
`endif

   ft_wishbone_master_if wb ();

   ft_wishbone_master #(.TIMEOUT(TMO), .SEL_ALL(4'hF)) dut (
      .clk(clk), .rst(rst), .master_ready(master_ready), .ih_ready(ih_ready),
      .in_command(in_command), .in_address(in_address), .in_data_count(in_data_count),
      .in_data(in_data), .oh_ready(oh_ready), .oh_en(oh_en), .out_status(out_status),
      .out_address(out_address), .out_data_count(out_data_count), .out_data(out_data),
      .state_dbg(state_dbg), .wb(wb)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   // ---------------- Wishbone slave model (negedge, single-cycle ack) ----------------
   always @(negedge clk) begin
      if (wb.wb_stb_o && !stb_prev) stb_rises++;
      stb_prev = wb.wb_stb_o;
      if (!wb.wb_stb_o && wb.wb_sel_o !== 4'h0) sel_viol++;
      if (wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i && slave_en) begin
         wb.wb_ack_i = 1'b1;
         wb.wb_dat_i = wb.wb_adr_o ^ 32'h5A5A;
         if (wb.wb_sel_o !== 4'hF) sel_viol++;
         if (wb.wb_we_o) begin
            wr_adr_q.push_back(wb.wb_adr_o);
            wr_dat_q.push_back(wb.wb_dat_o);
         end
      end else begin
         wb.wb_ack_i = 1'b0;
      end
   end

   // ---------------- response monitor ----------------
   always @(posedge clk) begin
      #1;
      if (rst) begin
         oh_prev = 1'b0;
      end else begin
         if (oh_en) begin
            if (!oh_ready) oh_viol++;
            if (oh_prev) oh_viol++;
            oh_st_q.push_back(out_status);
            oh_ad_q.push_back(out_address);
            oh_cn_q.push_back(out_data_count);
            oh_dt_q.push_back(out_data);
         end
         oh_prev = oh_en;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic host_req(input logic [31:0] cmd, input logic [31:0] addr,
                           input logic [27:0] cnt, input logic [31:0] data);
      @(negedge clk);
      in_command = cmd; in_address = addr; in_data_count = cnt; in_data = data;
      ih_ready = 1'b1;
      @(negedge clk);
      ih_ready = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (master_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_beats(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (oh_st_q.size() >= n) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic clear_logs();
      oh_st_q.delete(); oh_ad_q.delete(); oh_cn_q.delete(); oh_dt_q.delete();
      wr_adr_q.delete(); wr_dat_q.delete(); exp_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; ih_ready = 1'b0; oh_ready = 1'b0;
      in_command = '0; in_address = '0; in_data_count = '0; in_data = '0;
      wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;
      repeat (3) @(negedge clk);
      checks++; if (master_ready !== 1'b0) begin errors++; $display("FAIL reset_mr: got %b want 0", master_ready); end
      checks++; if (oh_en !== 1'b0) begin errors++; $display("FAIL reset_oh_en: got %b want 0", oh_en); end
      checks++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b want 00", wb.wb_cyc_o, wb.wb_stb_o); end
      checks++; if (wb.wb_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", wb.wb_sel_o); end
      checks++; if (out_status !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", out_status); end
      rst = 1'b0;
      #1;
      checks++; if (master_ready !== 1'b0) begin errors++; $display("FAIL release_mr_no_edge: got %b want 0", master_ready); end
      @(posedge clk); #1;
      checks++; if (master_ready !== 1'b1) begin errors++; $display("FAIL release_mr_first_edge: got %b want 1", master_ready); end
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL release_state: got %0d want 0", state_dbg); end
   endtask

   task automatic test_ping();
      bit ok;
      int rises0;
      clear_logs();
      rises0 = stb_rises;
      oh_ready = 1'b1;
      host_req(32'h0, 32'h1234, 28'd0, 32'h0);
      wait_beats(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ping_beat: got 0 beats want 1"); end
      if (ok) begin
         checks++; if (oh_st_q[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL ping_status: got %h want FFFFFFFF", oh_st_q[0]); end
         checks++; if (oh_ad_q[0] !== 32'h0) begin errors++; $display("FAIL ping_address: got %h want 0", oh_ad_q[0]); end
         checks++; if (oh_cn_q[0] !== 28'h0) begin errors++; $display("FAIL ping_count: got %h want 0", oh_cn_q[0]); end
      end
      wait_ready(ok);
      checks++; if (stb_rises != rises0) begin errors++; $display("FAIL ping_no_wb: got %0d cycles want 0", stb_rises - rises0); end
      checks++; if (oh_st_q.size() != 1) begin errors++; $display("FAIL ping_single_beat: got %0d want 1", oh_st_q.size()); end
   endtask

   task automatic test_write();
      bit ok;
      logic [31:0] wdata [3];
      wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC;
      clear_logs();
      oh_ready = 1'b1;
      host_req(32'h1, 32'h100, 28'd2, wdata[0]);
      for (int i = 1; i < 3; i++) begin
         wait_ready(ok);
         checks++; if (!ok) begin errors++; $display("FAIL write_wait_wdata%0d: master_ready got 0 want 1", i); end
         host_req(32'h1, 32'h100, 28'd2, wdata[i]);
      end
      wait_beats(1, ok);
      checks++; if (wr_adr_q.size() != 3) begin errors++; $display("FAIL write_count: got %0d want 3", wr_adr_q.size()); end
      for (int i = 0; i < 3 && i < wr_adr_q.size(); i++) begin
         checks++; if (wr_adr_q[i] !== 32'h100 + i) begin errors++; $display("FAIL write_adr%0d: got %h want %h", i, wr_adr_q[i], 32'h100 + i); end
         checks++; if (wr_dat_q[i] !== wdata[i]) begin errors++; $display("FAIL write_dat%0d: got %h want %h", i, wr_dat_q[i], wdata[i]); end
      end
      checks++; if (!ok) begin errors++; $display("FAIL write_resp_beat: got 0 beats want 1"); end
      if (ok) begin
         checks++; if (oh_st_q[0] !== 32'hFFFFFFFE) begin errors++; $display("FAIL write_status: got %h want FFFFFFFE", oh_st_q[0]); end
         checks++; if (oh_ad_q[0] !== 32'h100) begin errors++; $display("FAIL write_address: got %h want 100", oh_ad_q[0]); end
         checks++; if (oh_cn_q[0] !== 28'h0) begin errors++; $display("FAIL write_resp_count: got %h want 0", oh_cn_q[0]); end
      end
      wait_ready(ok);
      checks++; if (sel_viol != 0) begin errors++; $display("FAIL write_sel: got %0d bad sel samples want 0", sel_viol); end
   endtask

   task automatic test_read_stall();
      bit ok;
      int n0;
      logic [31:0] e;
      clear_logs();
      exp_q.push_back(32'h5A7A); exp_q.push_back(32'h5A7B);
      exp_q.push_back(32'h5A78); exp_q.push_back(32'h5A79);
      oh_ready = 1'b0;
      host_req(32'h2, 32'h20, 28'd3, 32'h0);
      for (int k = 0; k < 4; k++) begin
         n0 = oh_st_q.size();
         repeat (10) @(negedge clk);
         checks++; if (oh_st_q.size() != n0) begin errors++; $display("FAIL read_stall%0d: got %0d beats want %0d", k, oh_st_q.size(), n0); end
         oh_ready = 1'b1;
         wait_beats(k + 1, ok);
         oh_ready = 1'b0;
         checks++; if (!ok) begin errors++; $display("FAIL read_beat%0d: got %0d beats want %0d", k, oh_st_q.size(), k + 1); end
      end
      for (int k = 0; k < 4 && k < oh_st_q.size(); k++) begin
         e = exp_q.pop_front();
         checks++; if (oh_dt_q[k] !== e) begin errors++; $display("FAIL read_data%0d: got %h want %h", k, oh_dt_q[k], e); end
         checks++; if (oh_st_q[k] !== 32'hFFFFFFFD) begin errors++; $display("FAIL read_status%0d: got %h want FFFFFFFD", k, oh_st_q[k]); end
         checks++; if (oh_ad_q[k] !== 32'h20) begin errors++; $display("FAIL read_address%0d: got %h want 20", k, oh_ad_q[k]); end
         checks++; if (oh_cn_q[k] !== 28'd3) begin errors++; $display("FAIL read_count%0d: got %0d want 3", k, oh_cn_q[k]); end
      end
      oh_ready = 1'b1;
      wait_ready(ok);
      checks++; if (oh_viol != 0) begin errors++; $display("FAIL read_oh_rules: got %0d violations want 0", oh_viol); end
   endtask

   task automatic test_back_pressure();
      bit ok;
      int rises0;
      clear_logs();
      rises0 = stb_rises;
      oh_ready = 1'b1;
      slave_en = 1'b0;
      host_req(32'h1, 32'h300, 28'd0, 32'h55);
      @(negedge clk);
      checks++; if (master_ready !== 1'b0) begin errors++; $display("FAIL bp_mr_low: got %b want 0", master_ready); end
      host_req(32'h1, 32'h400, 28'd0, 32'h66);
      slave_en = 1'b1;
      wait_beats(1, ok);
      wait_ready(ok);
      repeat (5) @(negedge clk);
      checks++; if (stb_rises - rises0 != 1) begin errors++; $display("FAIL bp_wb_cycles: got %0d want 1", stb_rises - rises0); end
      checks++; if (wr_adr_q.size() != 1) begin errors++; $display("FAIL bp_writes: got %0d want 1", wr_adr_q.size()); end
      if (wr_adr_q.size() > 0) begin
         checks++; if (wr_adr_q[0] !== 32'h300 || wr_dat_q[0] !== 32'h55) begin errors++; $display("FAIL bp_write_word: got %h/%h want 300/55", wr_adr_q[0], wr_dat_q[0]); end
      end
      checks++; if (oh_st_q.size() != 1) begin errors++; $display("FAIL bp_beats: got %0d want 1", oh_st_q.size()); end
      if (oh_st_q.size() > 0) begin
         checks++; if (oh_ad_q[0] !== 32'h300) begin errors++; $display("FAIL bp_resp_address: got %h want 300", oh_ad_q[0]); end
      end
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int hi;
      clear_logs();
      oh_ready = 1'b1;
      slave_en = 1'b0;
      host_req(32'h2, 32'h80, 28'd0, 32'h0);
      hi = 0;
      repeat (30) begin
         if (wb.wb_stb_o) hi++;
         @(negedge clk);
      end
      checks++; if (hi != 8) begin errors++; $display("FAIL timeout_stb_cycles: got %0d want 8", hi); end
      checks++; if (wb.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL timeout_cyc: got %b want 0", wb.wb_cyc_o); end
      wait_beats(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_beat: got 0 beats want 1"); end
      if (ok) begin
         checks++; if (oh_st_q[0] !== 32'h7FFFFFFF) begin errors++; $display("FAIL timeout_status: got %h want 7FFFFFFF", oh_st_q[0]); end
         checks++; if (oh_ad_q[0] !== 32'h80) begin errors++; $display("FAIL timeout_address: got %h want 80", oh_ad_q[0]); end
      end
      slave_en = 1'b1;
      wait_ready(ok);
   endtask
`endif

   task automatic test_reset_mid_read();
      bit ok;
      int rises0;
      clear_logs();
      oh_ready = 1'b1;
      slave_en = 1'b0;
      host_req(32'h2, 32'h40, 28'd0, 32'h0);
      repeat (5) @(negedge clk);
      checks++; if (wb.wb_stb_o !== 1'b1) begin errors++; $display("FAIL mid_read_stb_held: got %b want 1", wb.wb_stb_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0) begin errors++; $display("FAIL async_cyc_stb: got %b%b want 00", wb.wb_cyc_o, wb.wb_stb_o); end
      checks++; if (oh_en !== 1'b0) begin errors++; $display("FAIL async_oh_en: got %b want 0", oh_en); end
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL async_state: got %0d want 0", state_dbg); end
      repeat (2) @(negedge clk);
      slave_en = 1'b1;
      rst = 1'b0;
      rises0 = stb_rises;
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL post_reset_ready: master_ready got 0 want 1"); end
      host_req(32'h0, 32'h0, 28'd0, 32'h0);
      wait_beats(1, ok);
      repeat (3) @(negedge clk);
      checks++; if (oh_st_q.size() != 1) begin errors++; $display("FAIL post_reset_beats: got %0d want 1", oh_st_q.size()); end
      if (oh_st_q.size() > 0) begin
         checks++; if (oh_st_q[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL post_reset_ping: got %h want FFFFFFFF", oh_st_q[0]); end
      end
      checks++; if (stb_rises != rises0) begin errors++; $display("FAIL post_reset_no_wb: got %0d cycles want 0", stb_rises - rises0); end
   endtask

   initial begin
      test_reset();
      test_ping();
      test_write();
      test_read_stall();
      test_back_pressure();
`ifdef WB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ft_wishbone_master.md
Name: ft_wishbone_master

Overview:
- Downstream consumer of the FT245 host interface. Takes decoded host requests (command, address, data count, data words) and runs them as Wishbone classic single transfers.
- Builds response packets (status, address, data count, data words) and returns them to the host interface's output handler.
- Single clock domain, shared with the host interface's internal side.

Parameters:
- TIMEOUT, 32'd1000, Wishbone ack timeout in clk cycles (used only with WB_TIMEOUT_EN).
- SEL_ALL, 4'hF, value driven on wb_sel_o for every transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- master_ready  out  1  block can accept an ih_ready pulse
- ih_ready  in  1  one-cycle pulse: in_* fields valid
- in_command  in  32  host command; [3:0]: 0=ping, 1=write, 2=read
- in_address  in  32  start word address
- in_data_count  in  28  write: words remaining after this one; read: words-1
- in_data  in  32  write data word
- oh_ready  in  1  output handler can take oh_en
- oh_en  out  1  one-cycle pulse: out_* fields valid
- out_status  out  32  response status
- out_address  out  32  response address
- out_data_count  out  28  response words-1
- out_data  out  32  response data word
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_sel_o  out  4  byte select (=SEL_ALL while stb is high, else 0)
- wb_ack_i  in  1  acknowledge

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, counters 0. master_ready rises on the first clk edge after reset release. Reset mid-transfer drops cyc/stb immediately; no response is sent.
- States: IDLE, WB_WRITE, WAIT_WDATA, WB_READ, WAIT_OH, SEND_DATA, SEND_RESP.
- IDLE: master_ready=1. An ih_ready sampled while master_ready=1 latches cmd, addr and count, then clears master_ready the next cycle. An ih_ready while master_ready=0 is ignored.
- Ping (cmd[3:0]=0): go to SEND_RESP. Response: status=~in_command (0xFFFFFFFF), address=0, count=0.
- Unknown cmd[3:0]: return to IDLE, no response.
- Write: WB_WRITE raises cyc, stb and we with adr=addr, dat=in_data.
  - On ack: drop stb/cyc the same edge; addr+1 (32-bit wrap).
  - If remaining>0: remaining-1, go to WAIT_WDATA (master_ready=1); the next ih_ready re-enters WB_WRITE with the new in_data.
  - If remaining=0: go to SEND_RESP. Response: status=~cmd (nibble E), address=start address, count=0.
- Read: words = in_data_count+1. WB_READ issues cyc/stb with we=0. On ack, capture wb_dat_i into out_data, drop stb/cyc, go to WAIT_OH.
  - First word: when oh_ready=1, pulse oh_en with status=~cmd (nibble D), address=start, count=in_data_count.
  - Later words: when oh_ready=1, pulse oh_en with the new out_data.
  - After each oh_en, if words remain: addr+1 and re-enter WB_READ; else IDLE.
- oh_en rules: one-cycle pulse, only while oh_ready=1, never on two consecutive cycles. out_* fields are held stable from oh_en until the next oh_en.
- SEND_RESP: wait for oh_ready=1, pulse oh_en, go to IDLE.
- Wishbone: one outstanding transfer; stb and cyc are asserted and deasserted together. An ack arriving without stb is ignored.
- Pipelining: one Wishbone transfer and one response beat per word; no buffering beyond one data word.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Enabled: a 32-bit counter clears on each stb rise and increments while stb=1 and ack=0. At TIMEOUT it drops cyc/stb, aborts the transfer, and goes to SEND_RESP with:
  - status={1'b0, ~cmd[30:4], 4'hF} (command-only error packet)
  - address=failing address, count=0
  - remaining write words are discarded: master_ready stays 0 until the response is sent.
- Disabled: no counter; the block waits for ack indefinitely.

Test Plan:
- Ping: ih_ready with cmd=0 -> one oh_en with out_status=0xFFFFFFFF, out_data_count=0; no wb_cyc_o.
- Write 3 words: cmd=1, addr=0x100, count=2, data 0xA,0xB,0xC over three ih_ready pulses -> Wishbone writes to 0x100/0x101/0x102 with those data, then one oh_en with status nibble E and address 0x100.
- Read 4 words: cmd=2, addr=0x20, count=3, slave returns addr^0x5A5A -> 4 oh_en pulses, first with count=3 and status nibble D, data matches; oh_ready held low 10 cycles between beats -> no oh_en during stall.
- Back-pressure: ih_ready pulsed while master_ready=0 -> ignored, no extra Wishbone cycle.
- Timeout (WB_TIMEOUT_EN, TIMEOUT=8): read to a slave that never acks -> cyc drops after 8 cycles, oh_en with status[3:0]=F and status[31]=0.
- Async reset mid-read with stb=1 -> cyc, stb and oh_en go to 0 without a clock; the next ping is serviced normally.
